pulse_demodulator: RTL and testbench
====================================

PULSE_DEMODULATOR -- requirements
Module: pulse_demodulator

Interface
REQ-001 SHALL have parameter CLK_RATE, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter DEADBAND, default 5000, neutral half-band in clock counts (50 us).
REQ-003 SHALL have parameter TIMEOUT, default 2500000, maximum rising-edge-to-rising-edge gap in counts (25 ms).
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port PulseIn  input  1  asynchronous servo-style pulse line.
REQ-007 SHALL have port Width  output  21  last accepted high-time in clock counts.
REQ-008 SHALL have port ModInfo  output  5  decoded command: [4:2] power level 0-7, [1:0] direction 0=forward, 1=neutral, 2=reverse.
REQ-009 SHALL have port Valid  output  1  one-cycle strobe when Width/ModInfo update.
REQ-010 SHALL have port PulseErr  output  1  one-cycle strobe on rejected pulse.
REQ-011 SHALL have port Timeout  output  1  level, no valid pulse within TIMEOUT.

Function
REQ-012 PulseIn SHALL pass a two-flop synchronizer; all edge detection uses the synchronized signal.
REQ-013 FSM states SHALL be WAIT_LOW, WAIT_RISE, MEASURE, DECODE.
REQ-014 WAIT_LOW -> WAIT_RISE when line low; WAIT_RISE -> MEASURE on rising edge; MEASURE -> DECODE on falling edge; DECODE -> WAIT_RISE after one cycle.
REQ-015 MEASURE SHALL count cycles with line high; counter saturates at 2^21-1.
REQ-016 Accepted range SHALL be 80000..220000 counts inclusive (0.8-2.2 ms at default CLK_RATE, scaled by CLK_RATE/100000000).
REQ-017 Out-of-range count in DECODE SHALL pulse PulseErr, leave Width/ModInfo unchanged, no Valid.
REQ-018 In-range count SHALL load Width, ModInfo, pulse Valid in the DECODE cycle; total latency falling edge (at pin) to Valid = 4 cycles.
REQ-019 Direction SHALL be neutral when |count-150000| <= DEADBAND; forward if below; reverse if above.
REQ-020 Power level SHALL be min(7, (|count-150000| - DEADBAND)/6250) for non-neutral, 0 for neutral; bin boundaries via constant comparator chain, no divider.
REQ-021 A gap counter SHALL reset on each rising edge; reaching TIMEOUT SHALL set Timeout and force ModInfo to 5'b00001 (neutral, level 0), Width unchanged.
REQ-022 Timeout SHALL clear on the next Valid; PulseErr does not clear it.
REQ-023 Line stuck high past TIMEOUT SHALL abort MEASURE to WAIT_LOW, pulse PulseErr, set Timeout.
REQ-024 Valid and PulseErr SHALL never assert in the same cycle.

Reset
REQ-025 RST SHALL force state WAIT_LOW, counters 0, Width 150000, ModInfo 5'b00001, Valid 0, PulseErr 0, Timeout 1.
REQ-026 RST asserted mid-MEASURE SHALL discard the partial pulse; first pulse after release is measured only after a low is seen.

Configuration
REQ-027 Macro PULSE_GLITCH_FILTER_EN defined: synchronized input SHALL change only after 8 consecutive equal samples (adds 8 cycles latency, Verification values shift accordingly).
REQ-028 Macro undefined: synchronizer output used directly, no filter logic present.

Structure
REQ-029 Shared package SHALL hold direction encodings (FWD=0, NEU=1, REV=2), NEUTRAL_COUNT 150000, MIN/MAX accept counts, bin width 6250, FSM state encoding.
REQ-030 Synchronizer plus optional glitch filter SHALL be sub-module pulse_in_sync.

Verification
REQ-031 150000-count pulse, 20 ms period -> Valid, Width=150000, ModInfo=5'b00001, Timeout cleared.
REQ-032 100000-count pulse -> ModInfo dir=0, level=7; 140000 -> dir=0, level=0 (distance 10000-5000=5000 <6250); 162000 -> dir=2, level=1.
REQ-033 50000-count and 250000-count pulses -> PulseErr strobe, no Valid, outputs unchanged.
REQ-034 Line held low 30 ms after valid traffic -> Timeout=1 at 2500000 cycles after last rise, ModInfo=5'b00001; next good pulse clears it.
REQ-035 RST asserted 60000 cycles into a pulse -> reset values; trailing remainder of that pulse not reported.
REQ-036 With PULSE_GLITCH_FILTER_EN, 3-cycle low glitch inside a 150000-count pulse -> single Valid, Width=150000.

Source files
------------

// File: rtl/pulse_demodulator_pkg.sv
// -----------------------------------------------------------------------------
// pulse_demodulator_pkg
// Shared constants and types for the servo-style pulse demodulator.
//   - Direction encodings carried in ModInfo[1:0]
//   - Reference pulse-width constants, expressed in counts at a 100 MHz clock
//   - FSM state encoding (plain localparams)
//   - mod_info_t : packed {level[2:0], dir[1:0]} matching the ModInfo port
//   - scale_count(): rescales a 100 MHz reference count to another clock rate
// -----------------------------------------------------------------------------
package pulse_demodulator_pkg;

  // Direction field of ModInfo
  localparam logic [1:0] DIR_FWD = 2'd0;
  localparam logic [1:0] DIR_NEU = 2'd1;
  localparam logic [1:0] DIR_REV = 2'd2;

  // Reference counts at REF_CLK_RATE
  localparam int unsigned REF_CLK_RATE     = 100000000;
  localparam int unsigned NEUTRAL_COUNT    = 150000;
  localparam int unsigned MIN_ACCEPT_COUNT = 80000;
  localparam int unsigned MAX_ACCEPT_COUNT = 220000;
  localparam int unsigned BIN_WIDTH        = 6250;

  localparam int WIDTH_W   = 21;
  localparam int MAX_LEVEL = 7;

  // FSM state encoding
  localparam logic [1:0] ST_WAIT_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;
  localparam logic [1:0] ST_DECODE    = 2'd3;

  typedef struct packed {
    logic [2:0] level;
    logic [1:0] dir;
  } mod_info_t;

  localparam mod_info_t MOD_NEUTRAL = '{level: 3'd0, dir: DIR_NEU};

  // 64-bit intermediate: 220000 * 1e8 does not fit in 32 bits.
  function automatic int unsigned scale_count(input int unsigned base,
                                              input int unsigned clk_rate);
    logic [63:0] prod;
    prod = 64'(base) * 64'(clk_rate);
    return 32'(prod / 64'(REF_CLK_RATE));
  endfunction

endpackage

// File: rtl/pulse_in_sync.sv
// -----------------------------------------------------------------------------
// pulse_in_sync
// Two-flop synchronizer for the asynchronous pulse line, with an optional
// glitch filter selected by the macro PULSE_GLITCH_FILTER_EN.
//   CLK      in  clock, rising edge
//   RST      in  asynchronous active-high reset
//   i_pulse  in  raw asynchronous pulse line
//   o_pulse  out synchronized (and, if enabled, filtered) pulse line
// Macro PULSE_GLITCH_FILTER_EN: output changes only after 8 consecutive
// synchronized samples disagree with it (adds 8 cycles of latency).
// -----------------------------------------------------------------------------
module pulse_in_sync (
  input  logic CLK,
  input  logic RST,
  input  logic i_pulse,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;

  // Reset to "high" so a line that is high when reset releases is never
  // mistaken for a fresh rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_pulse;
      r_sync <= r_meta;
    end
  end

`ifdef PULSE_GLITCH_FILTER_EN
  logic       r_filt;
  logic [2:0] r_run;

  // r_run counts consecutive samples that differ from the current output;
  // the eighth such sample commits the change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_filt <= 1'b1;
      r_run  <= 3'd0;
    end else if (r_sync == r_filt) begin
      r_run <= 3'd0;
    end else if (r_run == 3'd7) begin
      r_filt <= r_sync;
      r_run  <= 3'd0;
    end else begin
      r_run <= r_run + 3'd1;
    end
  end

  assign o_pulse = r_filt;
`else
  assign o_pulse = r_sync;
`endif

endmodule

// File: rtl/pulse_demodulator.sv
// -----------------------------------------------------------------------------
// pulse_demodulator
// Measures the high time of a servo-style pulse line and decodes it into a
// direction and a power level.
//   CLK       in   sole clock, rising edge
//   RST       in   asynchronous active-high reset
//   PulseIn   in   asynchronous pulse line
//   Width     out  [20:0] last accepted high time in clock counts
//   ModInfo   out  [4:0]  [4:2] power level 0-7, [1:0] dir 0=fwd 1=neu 2=rev
//   Valid     out  one-cycle strobe when Width/ModInfo update
//   PulseErr  out  one-cycle strobe on a rejected pulse
//   Timeout   out  level, no valid pulse within TIMEOUT counts
// Parameters: CLK_RATE (Hz), DEADBAND (counts), TIMEOUT (counts).
// Macro PULSE_GLITCH_FILTER_EN enables the input glitch filter in
// pulse_in_sync; the default build uses the plain synchronizer.
// Latency from falling edge at the pin to Valid: 4 cycles (sync 2, FSM 1,
// registered decode 1).
// -----------------------------------------------------------------------------
module pulse_demodulator
  import pulse_demodulator_pkg::*;
#(
  parameter int unsigned CLK_RATE = 100000000,
  parameter int unsigned DEADBAND = 5000,
  parameter int unsigned TIMEOUT  = 2500000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PulseIn,
  output logic [WIDTH_W-1:0] Width,
  output logic [4:0]         ModInfo,
  output logic               Valid,
  output logic               PulseErr,
  output logic               Timeout
);

  // Pulse-width limits rescaled to the actual clock rate
  localparam int unsigned MIN_CNT = scale_count(MIN_ACCEPT_COUNT, CLK_RATE);
  localparam int unsigned MAX_CNT = scale_count(MAX_ACCEPT_COUNT, CLK_RATE);
  localparam int unsigned NEU_CNT = scale_count(NEUTRAL_COUNT, CLK_RATE);
  localparam int unsigned BIN_CNT = scale_count(BIN_WIDTH, CLK_RATE);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH_W-1:0] CNT_SAT = '1;

  // ---------------------------------------------------------------------------
  // Input conditioning and edge detection
  // ---------------------------------------------------------------------------
  logic w_line;
  logic r_line_d;
  logic w_rise;
  logic w_fall;

  pulse_in_sync u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .i_pulse (PulseIn),
    .o_pulse (w_line)
  );

  assign w_rise = w_line & ~r_line_d;
  assign w_fall = ~w_line & r_line_d;

  // ---------------------------------------------------------------------------
  // State, width counter, gap counter
  // ---------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH_W-1:0] r_count;
  logic [GAP_W-1:0]   r_gap;
  logic               w_gap_hit;

  // Fires once, on the cycle the gap counter would reach TIMEOUT. A rise in
  // the same cycle restarts the gap, so it wins.
  assign w_gap_hit = (r_gap == GAP_W'(TIMEOUT - 1)) && !w_rise;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_LOW:  if (!w_line) w_state_next = ST_WAIT_RISE;
      ST_WAIT_RISE: if (w_rise)  w_state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (w_gap_hit)   w_state_next = ST_WAIT_LOW;   // stuck high
        else if (w_fall) w_state_next = ST_DECODE;
      end
      ST_DECODE:    w_state_next = ST_WAIT_RISE;
      default:      w_state_next = ST_WAIT_LOW;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_WAIT_LOW;
      r_line_d <= 1'b1;
      r_count  <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_line_d <= w_line;

      if (w_rise)
        r_gap <= '0;
      else if (r_gap != GAP_W'(TIMEOUT))
        r_gap <= r_gap + 1'b1;

      // The rising-edge cycle is itself a high cycle, so the count starts
      // at 1. r_count is held through DECODE for the decoder.
      case (r_state)
        ST_WAIT_RISE: r_count <= w_rise ? WIDTH_W'(1) : '0;
        ST_MEASURE:   if (w_line && r_count != CNT_SAT) r_count <= r_count + 1'b1;
        ST_DECODE:    r_count <= r_count;
        default:      r_count <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the measured width (evaluated while in DECODE)
  // ---------------------------------------------------------------------------
  logic [31:0]          w_count32;
  logic [31:0]          w_dist;
  logic [31:0]          w_excess;
  logic                 w_in_range;
  logic                 w_neutral;
  logic [MAX_LEVEL-1:0] w_therm;
  logic [2:0]           w_level;
  mod_info_t            w_mod_decoded;

  assign w_count32  = 32'(r_count);
  assign w_in_range = (w_count32 >= MIN_CNT) && (w_count32 <= MAX_CNT);
  assign w_dist     = (w_count32 >= NEU_CNT) ? (w_count32 - NEU_CNT)
                                             : (NEU_CNT - w_count32);
  assign w_neutral  = (w_dist <= DEADBAND);
  assign w_excess   = w_neutral ? 32'd0 : (w_dist - DEADBAND);

  // Constant comparator chain: one threshold per level boundary, forming a
  // thermometer code whose population count is the saturated level.
  for (genvar gi = 0; gi < MAX_LEVEL; gi++) begin : g_bin
    localparam int unsigned THRESH = 32'(gi + 1) * BIN_CNT;
    assign w_therm[gi] = (w_excess >= THRESH);
  end

  always_comb begin
    w_level = 3'd0;
    for (int i = 0; i < MAX_LEVEL; i++)
      w_level = w_level + {2'b00, w_therm[i]};
  end

  always_comb begin
    w_mod_decoded = MOD_NEUTRAL;
    if (!w_neutral) begin
      w_mod_decoded.level = w_level;
      w_mod_decoded.dir   = (w_count32 < NEU_CNT) ? DIR_FWD : DIR_REV;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [WIDTH_W-1:0] r_width;
  mod_info_t          r_mod_info;
  logic               r_valid;
  logic               r_err;
  logic               r_timeout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_width    <= WIDTH_W'(NEU_CNT);
      r_mod_info <= MOD_NEUTRAL;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_gap_hit) begin
        r_timeout  <= 1'b1;
        r_mod_info <= MOD_NEUTRAL;
      end

      // Abort of a stuck-high pulse happens in MEASURE and rejection in
      // DECODE, so Valid and PulseErr can never coincide.
      if (r_state == ST_MEASURE && w_gap_hit)
        r_err <= 1'b1;

      if (r_state == ST_DECODE) begin
        if (w_in_range) begin
          r_width    <= r_count;
          r_mod_info <= w_mod_decoded;
          r_valid    <= 1'b1;
          r_timeout  <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign Width    = r_width;
  assign ModInfo  = r_mod_info;
  assign Valid    = r_valid;
  assign PulseErr = r_err;
  assign Timeout  = r_timeout;

endmodule

// File: tb/tb_pulse_demodulator.sv
// Bench for pulse_demodulator at a scaled clock rate so every scenario fits in
// a short run. CLK_RATE=400000 scales reference counts by 1/250:
// neutral 600, accept 320..880, bin 25, deadband 20, timeout 2000.
module tb_pulse_demodulator;

  localparam int unsigned P_CLK_RATE = 400000;
  localparam int unsigned P_DEADBAND = 20;
  localparam int unsigned P_TIMEOUT  = 2000;
`ifdef PULSE_GLITCH_FILTER_EN
  localparam int EXTRA = 8;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 4 + EXTRA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_in = 1'b0;
  logic [20:0] width;
  logic [4:0]  mod_info;
  logic        valid;
  logic        pulse_err;
  logic        timeout;

  pulse_demodulator #(
    .CLK_RATE (P_CLK_RATE),
    .DEADBAND (P_DEADBAND),
    .TIMEOUT  (P_TIMEOUT)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .PulseIn  (pulse_in),
    .Width    (width),
    .ModInfo  (mod_info),
    .Valid    (valid),
    .PulseErr (pulse_err),
    .Timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Scoreboard entry: one expected Valid/PulseErr event
  typedef struct {
    bit          is_err;
    logic [20:0] width;
    logic [4:0]  mod;
    bit          tmo;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Bench model of the output registers
  logic [20:0] m_width = 21'd600;
  logic [4:0]  m_mod   = 5'b00001;
  bit          m_tmo   = 1'b1;

  task automatic push(input bit is_err, input logic [20:0] w, input logic [4:0] m, input int due);
    exp_t e;
    if (!is_err) begin
      m_width = w;
      m_mod   = m;
      m_tmo   = 1'b0;
    end
    e.is_err = is_err;
    e.width  = m_width;
    e.mod    = m_mod;
    e.tmo    = m_tmo;
    e.due    = due;
    sb.push_back(e);
  endtask

  // Monitor: every output event is popped and compared
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid || pulse_err)) begin
      $display("cycle %0d: %s width=%0d modinfo=%b timeout=%0b",
               cyc, valid ? "valid" : "pulse_err", width, mod_info, timeout);
      check("valid_err_exclusive", {31'd0, valid & pulse_err}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_is_err", {31'd0, pulse_err}, {31'd0, e.is_err});
        check("width", {11'd0, width}, {11'd0, e.width});
        check("modinfo", {27'd0, mod_info}, {27'd0, e.mod});
        check("timeout_at_event", {31'd0, timeout}, {31'd0, e.tmo});
        if (e.due >= 0) check("latency_cycle", cyc, e.due);
      end
    end
  end

  int rise_cyc = 0;

  // kind: 0 = no event expected, 1 = Valid, 2 = PulseErr
  task automatic send(input int hi, input int lo, input int kind,
                      input logic [20:0] w, input logic [4:0] m);
    @(negedge clk);
    pulse_in = 1'b1;
    rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    pulse_in = 1'b0;
    if (kind != 0) push(kind == 2, w, m, cyc + LAT);
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [20:0] w,
                               input logic [4:0] m, input bit t);
    check({tag, "_width"}, {11'd0, width}, {11'd0, w});
    check({tag, "_modinfo"}, {27'd0, mod_info}, {27'd0, m});
    check({tag, "_timeout"}, {31'd0, timeout}, {31'd0, t});
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_pulse_err"}, {31'd0, pulse_err}, 32'd0);
  endtask

  typedef struct {
    int          hi;
    bit          ok;
    logic [20:0] width;
    logic [4:0]  mod;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int target;

    // high time, accepted, expected Width, expected ModInfo ({level, dir})
    tbl[0]  = '{600,  1'b1, 21'd600, 5'b00001};  // centre: neutral
    tbl[1]  = '{400,  1'b1, 21'd400, 5'b11100};  // fwd, saturated level 7
    tbl[2]  = '{560,  1'b1, 21'd560, 5'b00000};  // fwd, excess 20 < 25
    tbl[3]  = '{648,  1'b1, 21'd648, 5'b00110};  // rev, level 1
    tbl[4]  = '{200,  1'b0, 21'd0,   5'b00000};  // too short
    tbl[5]  = '{1000, 1'b0, 21'd0,   5'b00000};  // too long
    tbl[6]  = '{320,  1'b1, 21'd320, 5'b11100};  // min accepted
    tbl[7]  = '{319,  1'b0, 21'd0,   5'b00000};  // just below min
    tbl[8]  = '{880,  1'b1, 21'd880, 5'b11110};  // max accepted
    tbl[9]  = '{881,  1'b0, 21'd0,   5'b00000};  // just above max
    tbl[10] = '{620,  1'b1, 21'd620, 5'b00001};  // deadband edge: neutral
    tbl[11] = '{621,  1'b1, 21'd621, 5'b00010};  // just outside deadband
    tbl[12] = '{645,  1'b1, 21'd645, 5'b00110};  // first bin boundary
    tbl[13] = '{644,  1'b1, 21'd644, 5'b00010};  // just below boundary
    tbl[14] = '{555,  1'b1, 21'd555, 5'b00100};  // fwd, level 1
    tbl[15] = '{600,  1'b1, 21'd600, 5'b00001};  // back to neutral

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_outputs("reset", 21'd600, 5'b00001, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table-driven pulses
    for (int i = 0; i < 16; i++)
      send(tbl[i].hi, 100, tbl[i].ok ? 1 : 2, tbl[i].width, tbl[i].mod);

    // Line held low: Timeout rises TIMEOUT cycles after the synchronized rise
    send(400, 50, 1, 21'd400, 5'b11100);
    target = rise_cyc + int'(P_TIMEOUT) + 2 + EXTRA;
    while (cyc < target) @(negedge clk);
    check("timeout_before_limit", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    check("timeout_at_limit", {31'd0, timeout}, 32'd1);
    check("timeout_modinfo", {27'd0, mod_info}, 32'd1);
    check("timeout_width_kept", {11'd0, width}, 32'd400);
    m_tmo = 1'b1;
    m_mod = 5'b00001;
    send(648, 100, 1, 21'd648, 5'b00110);   // good pulse clears Timeout

    // Line stuck high: MEASURE aborts with PulseErr and Timeout
    @(negedge clk);
    pulse_in = 1'b1;
    rise_cyc = cyc;
    m_tmo = 1'b1;
    m_mod = 5'b00001;
    push(1'b1, 21'd0, 5'd0, rise_cyc + int'(P_TIMEOUT) + 3 + EXTRA);
    repeat (int'(P_TIMEOUT) + 200) @(negedge clk);
    pulse_in = 1'b0;
    repeat (100) @(negedge clk);
    check("stuck_high_drained", sb.size(), 32'd0);
    check("stuck_high_timeout", {31'd0, timeout}, 32'd1);
    send(600, 100, 1, 21'd600, 5'b00001);
    send(648, 100, 1, 21'd648, 5'b00110);

    // Reset in the middle of a pulse: remainder must not be reported
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (240) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs("midpulse_reset", 21'd600, 5'b00001, 1'b1);
    m_width = 21'd600;
    m_mod   = 5'b00001;
    m_tmo   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    pulse_in = 1'b0;
    repeat (100) @(negedge clk);
    check_outputs("after_reset_remainder", 21'd600, 5'b00001, 1'b1);
    send(560, 100, 1, 21'd560, 5'b00000);

`ifdef PULSE_GLITCH_FILTER_EN
    // Short low glitch inside a neutral pulse is absorbed by the filter
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (300) @(negedge clk);
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    pulse_in = 1'b1;
    repeat (297) @(negedge clk);
    pulse_in = 1'b0;
    push(1'b0, 21'd600, 5'b00001, cyc + LAT);
    repeat (100) @(negedge clk);
`endif

    repeat (LAT + 10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
